// File: rtl/mem_io_ctrl_pkg.sv
// Shared definitions for the stage-2 memory/IO controller: opcodes, address
// regions, MMIO offsets, write-back select encodings and FSM states.
package mem_io_ctrl_pkg;

  // Load/store opcodes (Instruction[31:26])
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  // Address regions (Address[31:28])
  localparam logic [3:0] REG_DMEM = 4'h1;
  localparam logic [3:0] REG_IMEM = 4'h2;
  localparam logic [3:0] REG_BOTH = 4'h3;
  localparam logic [3:0] REG_MMIO = 4'h8;

  // MMIO register offsets (Address[7:0])
  localparam logic [7:0] MMIO_TX_STAT = 8'h00;
  localparam logic [7:0] MMIO_RX_STAT = 8'h04;
  localparam logic [7:0] MMIO_RX_DATA = 8'h08;
  localparam logic [7:0] MMIO_TX_DATA = 8'h0C;
  localparam logic [7:0] MMIO_CYC_CNT = 8'h10;
  localparam logic [7:0] MMIO_INS_CNT = 8'h14;
  localparam logic [7:0] MMIO_CNT_RST = 8'h18;

  // Write-back source select
  typedef enum logic [1:0] {
    RDSEL_UART = 2'b00,
    RDSEL_ALU  = 2'b01,
    RDSEL_DMEM = 2'b10,
    RDSEL_CNT  = 2'b11
  } rdsel_e;

  // UART read-port select
  typedef enum logic [1:0] {
    USEL_RX_DATA = 2'b00,
    USEL_TX_STAT = 2'b01,
    USEL_RX_STAT = 2'b10
  } uartsel_e;

  // Transmit-store handshake FSM
  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_TX_WAIT = 1'b1
  } state_e;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Big-endian byte lanes: bit3 covers data bits [31:24]
  function automatic logic [3:0] byte_sel(input logic [5:0] op, input logic [1:0] off);
    logic [3:0] bs;
    bs = '0;
    case (op)
      OP_SW:   bs = 4'b1111;
      OP_SH:   bs = off[1] ? 4'b0011 : 4'b1100;
      OP_SB:   bs = 4'b1000 >> off;
      default: bs = '0;
    endcase
    return bs;
  endfunction

endpackage

// File: rtl/mem_io_ctrl_mmio_counters.sv
// Memory-mapped cycle and retired-instruction counters with a shared clear
// strobe and the read-back mux.
module mmio_counters
  import mem_io_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_req_i,
  input  logic        stall_i,
  input  logic        instr_nz_i,
  input  logic        rd_cnt_i,
  input  logic        sel_instr_i,
  output logic        clr_o,
  output logic [31:0] cnt_data_o
);

  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] ins_q, ins_d;

  // Next counter values; a clear wins over the increment of the same cycle
  always_comb begin
    clr_o = clr_req_i & ~stall_i;
    cyc_d = cyc_q + CNT_W'(1);
    ins_d = ins_q;
    if (!stall_i && instr_nz_i) begin
      ins_d = ins_q + CNT_W'(1);
    end
    if (clr_o) begin
      cyc_d = '0;
      ins_d = '0;
    end
  end

  // Counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ins_q <= ins_d;
    end
  end

  // Read-back: zero unless a counter register is being loaded
  always_comb begin
    cnt_data_o = '0;
    if (rd_cnt_i) begin
      cnt_data_o = sel_instr_i ? 32'(ins_q) : 32'(cyc_q);
    end
  end

endmodule

// File: rtl/mem_io_ctrl.sv
// Stage-2 memory/IO controller: decodes loads/stores against the address
// map, drives memory and UART strobes, and stalls the pipeline while a UART
// transmit store waits for the transmitter.
module mem_io_ctrl
  import mem_io_ctrl_pkg::*;
#(
  parameter int unsigned TX_TIMEOUT = 1024,
  parameter int unsigned CNT_W      = 32
) (
  input  logic        CLK,
  input  logic        reset_n,
  input  logic [31:0] Instruction,
  input  logic [31:0] Address,
  input  logic        DataInReady,
  input  logic        DataOutValid,
  output logic        Stall,
  output logic        WEDM,
  output logic        WEIM,
  output logic [3:0]  ByteSel,
  output logic        REUART,
  output logic        WEUART,
  output logic [1:0]  UARTsel,
  output logic [1:0]  RDsel,
  output logic [31:0] CntData,
  output logic        TxTimeoutErr
);

  // The entry cycle in RUN already stalls once, so TX_WAIT gives up after
  // TX_TIMEOUT-2 further stalled cycles: TX_TIMEOUT-1 stalls in total, the
  // store being dropped on the TX_TIMEOUT-th cycle. TX_TIMEOUT must be >= 2.
  localparam int unsigned     TMO_W    = $clog2(TX_TIMEOUT) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TX_TIMEOUT - 2);

  state_e           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;

  logic [5:0]  op;
  logic [3:0]  region;
  logic [7:0]  off;
  logic        ld, st, mmio;
  logic        tx_store, cnt_rst_store, cnt_rd;
  logic        stall_c, weuart_c, err_set;
  logic        cnt_clr;
  logic [31:0] cnt_data;

  assign op     = Instruction[31:26];
  assign region = Address[31:28];
  assign off    = Address[7:0];
  assign ld     = is_load(op);
  assign st     = is_store(op);
  assign mmio   = (region == REG_MMIO) && (Address[27:8] == '0);

  assign tx_store      = st & mmio & (off == MMIO_TX_DATA);
  assign cnt_rst_store = st & mmio & (off == MMIO_CNT_RST);
  assign cnt_rd        = ld & mmio & ((off == MMIO_CYC_CNT) || (off == MMIO_INS_CNT));

  // Transmit handshake: next state, timeout count, stall and TX strobe
  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    stall_c  = 1'b0;
    weuart_c = 1'b0;
    err_set  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (tx_store) begin
          if (DataInReady) begin
            weuart_c = 1'b1;
          end else begin
            stall_c = 1'b1;
            state_d = ST_TX_WAIT;
            tmo_d   = '0;
          end
        end
      end
      ST_TX_WAIT: begin
        if (DataInReady) begin
          weuart_c = 1'b1;
          state_d  = ST_RUN;
        end else if (tmo_q == TMO_LAST) begin
          err_set = 1'b1;
          state_d = ST_RUN;
        end else begin
          stall_c = 1'b1;
          tmo_d   = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Sticky timeout flag; the counter-reset store also clears it
  always_comb begin
    err_d = err_q;
    if (err_set) err_d = 1'b1;
    if (cnt_clr) err_d = 1'b0;
  end

  // FSM, timeout counter and error flag registers
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  // Decode outputs, all held at their idle values while reset is asserted
  always_comb begin
    Stall   = 1'b0;
    WEDM    = 1'b0;
    WEIM    = 1'b0;
    ByteSel = '0;
    REUART  = 1'b0;
    WEUART  = 1'b0;
    UARTsel = USEL_RX_DATA;
    RDsel   = RDSEL_ALU;
    CntData = '0;
    if (reset_n) begin
      Stall   = stall_c;
      WEUART  = weuart_c;
      CntData = cnt_data;
      if (st && !stall_c) begin
        case (region)
          REG_DMEM: WEDM = 1'b1;
          REG_IMEM: WEIM = 1'b1;
          REG_BOTH: begin
            WEDM = 1'b1;
            WEIM = 1'b1;
          end
          default: ;
        endcase
      end
      if (WEDM || WEIM) begin
        ByteSel = byte_sel(op, off[1:0]);
      end
      if (ld) begin
        RDsel = RDSEL_DMEM;
        if (mmio) begin
          case (off)
            MMIO_TX_STAT: begin
              RDsel   = RDSEL_UART;
              UARTsel = USEL_TX_STAT;
            end
            MMIO_RX_STAT: begin
              RDsel   = RDSEL_UART;
              UARTsel = USEL_RX_STAT;
            end
            MMIO_RX_DATA: begin
              RDsel   = RDSEL_UART;
              UARTsel = USEL_RX_DATA;
              REUART  = DataOutValid & ~stall_c;
            end
            MMIO_CYC_CNT, MMIO_INS_CNT: RDsel = RDSEL_CNT;
            default: ;
          endcase
        end
      end
    end
  end

  assign TxTimeoutErr = err_q;

  mmio_counters #(
    .CNT_W (CNT_W)
  ) u_counters (
    .clk_i       (CLK),
    .rst_ni      (reset_n),
    .clr_req_i   (cnt_rst_store),
    .stall_i     (Stall),
    .instr_nz_i  (|Instruction),
    .rd_cnt_i    (cnt_rd),
    .sel_instr_i (Address[2]),
    .clr_o       (cnt_clr),
    .cnt_data_o  (cnt_data)
  );

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Scoreboard bench for mem_io_ctrl: the driver applies one vector per cycle
// and queues its expected outputs; the monitor compares on the falling edge.
module tb_mem_io_ctrl;

  logic        CLK = 1'b0;
  logic        reset_n;
  logic [31:0] Instruction, Address;
  logic        DataInReady, DataOutValid;
  logic        Stall, WEDM, WEIM, REUART, WEUART, TxTimeoutErr;
  logic [3:0]  ByteSel;
  logic [1:0]  UARTsel, RDsel;
  logic [31:0] CntData;

  always #5 CLK = ~CLK;

  mem_io_ctrl #(
    .TX_TIMEOUT (8),
    .CNT_W      (32)
  ) dut (
    .CLK          (CLK),
    .reset_n      (reset_n),
    .Instruction  (Instruction),
    .Address      (Address),
    .DataInReady  (DataInReady),
    .DataOutValid (DataOutValid),
    .Stall        (Stall),
    .WEDM         (WEDM),
    .WEIM         (WEIM),
    .ByteSel      (ByteSel),
    .REUART       (REUART),
    .WEUART       (WEUART),
    .UARTsel      (UARTsel),
    .RDsel        (RDsel),
    .CntData      (CntData),
    .TxTimeoutErr (TxTimeoutErr)
  );

  localparam logic [5:0] LB = 6'h20, LW = 6'h23, LBU = 6'h24, LHU = 6'h25;
  localparam logic [5:0] SB = 6'h28, SH = 6'h29, SW = 6'h2B, LWL = 6'h22;
  localparam logic [1:0] RS_UART = 2'b00, RS_ALU = 2'b01, RS_DMEM = 2'b10, RS_CNT = 2'b11;
  localparam logic [1:0] US_RXD = 2'b00, US_TXS = 2'b01, US_RXS = 2'b10;
  localparam logic [31:0] FILL = 32'h00221820;
  localparam logic [31:0] A_TX = 32'h8000000C;

  typedef struct {
    string       nm;
    logic [13:0] ex;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [31:0] I(input logic [5:0] op);
    return {op, 26'h00000A5};
  endfunction

  // {Stall,WEDM,WEIM,ByteSel,REUART,WEUART,UARTsel,RDsel,TxTimeoutErr}
  function automatic logic [13:0] E(input logic st, input logic wd, input logic wi,
                                    input logic [3:0] bs, input logic re, input logic wu,
                                    input logic [1:0] us, input logic [1:0] rs,
                                    input logic er);
    return {st, wd, wi, bs, re, wu, us, rs, er};
  endfunction

  function automatic logic [13:0] idle(input logic er);
    return E(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, US_RXD, RS_ALU, er);
  endfunction

  task automatic drive(input logic rstn, input logic [31:0] ins, input logic [31:0] addr,
                       input logic rdy, input logic vld, input string nm,
                       input logic [13:0] ex, input logic [31:0] cnt);
    exp_t e;
    @(posedge CLK);
    #1;
    reset_n      = rstn;
    Instruction  = ins;
    Address      = addr;
    DataInReady  = rdy;
    DataOutValid = vld;
    e.nm  = nm;
    e.ex  = ex;
    e.cnt = cnt;
    sb_q.push_back(e);
  endtask

  // Monitor: compare every queued expectation against the settled outputs
  always @(negedge CLK) begin
    exp_t        e;
    logic [13:0] act;
    if (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      act = {Stall, WEDM, WEIM, ByteSel, REUART, WEUART, UARTsel, RDsel, TxTimeoutErr};
      n_cmp++;
      if (act !== e.ex) begin
        n_bad++;
        $display("FAIL %s ctl: got %b required %b (St WD WI BS RE WU US RS Er)", e.nm, act, e.ex);
      end
      n_cmp++;
      if (CntData !== e.cnt) begin
        n_bad++;
        $display("FAIL %s CntData: got %0d required %0d", e.nm, CntData, e.cnt);
      end
    end
  end

  initial begin
    reset_n = 1'b0; Instruction = '0; Address = '0; DataInReady = 1'b0; DataOutValid = 1'b0;

    // Reset holds every output idle even for a blocking TX store / valid RX load
    drive(0, I(SW), A_TX,         0, 0, "rst_tx",  idle(0), 0);
    drive(0, I(LW), 32'h80000008, 0, 1, "rst_rx",  idle(0), 0);
    drive(1, I(LW), 32'h80000010, 0, 0, "cyc_rst", E(0,0,0,4'b0000,0,0,US_RXD,RS_CNT,0), 0);

    // Stores: byte lanes and region enables
    drive(1, I(SB), 32'h10000002, 0, 0, "sb_2",    E(0,1,0,4'b0010,0,0,US_RXD,RS_ALU,0), 0);
    drive(1, I(SH), 32'h10000002, 0, 0, "sh_2",    E(0,1,0,4'b0011,0,0,US_RXD,RS_ALU,0), 0);
    drive(1, I(SH), 32'h10000000, 0, 0, "sh_0",    E(0,1,0,4'b1100,0,0,US_RXD,RS_ALU,0), 0);
    drive(1, I(SB), 32'h10000000, 0, 0, "sb_0",    E(0,1,0,4'b1000,0,0,US_RXD,RS_ALU,0), 0);
    drive(1, I(SB), 32'h10000003, 0, 0, "sb_3",    E(0,1,0,4'b0001,0,0,US_RXD,RS_ALU,0), 0);
    drive(1, I(SW), 32'h30000000, 0, 0, "sw_both", E(0,1,1,4'b1111,0,0,US_RXD,RS_ALU,0), 0);
    drive(1, I(SW), 32'h50000000, 0, 0, "sw_unmap", idle(0), 0);
    drive(1, I(SW), 32'h20000004, 0, 0, "sw_imem", E(0,0,1,4'b1111,0,0,US_RXD,RS_ALU,0), 0);

    // Loads: write-back selects
    drive(1, I(LW),  32'h10000000, 0, 0, "lw_dmem",  E(0,0,0,4'b0000,0,0,US_RXD,RS_DMEM,0), 0);
    drive(1, I(LW),  32'h30000000, 0, 0, "lw_both",  E(0,0,0,4'b0000,0,0,US_RXD,RS_DMEM,0), 0);
    drive(1, I(LBU), 32'h50000000, 0, 0, "lbu_unm",  E(0,0,0,4'b0000,0,0,US_RXD,RS_DMEM,0), 0);
    drive(1, I(LHU), 32'h20000000, 0, 0, "lhu_imem", E(0,0,0,4'b0000,0,0,US_RXD,RS_DMEM,0), 0);
    drive(1, I(LW),  32'h80000008, 0, 0, "rx_nv",    E(0,0,0,4'b0000,0,0,US_RXD,RS_UART,0), 0);
    drive(1, I(LW),  32'h80000008, 0, 1, "rx_v",     E(0,0,0,4'b0000,1,0,US_RXD,RS_UART,0), 0);
    drive(1, I(LW),  32'h80000000, 0, 0, "tx_stat",  E(0,0,0,4'b0000,0,0,US_TXS,RS_UART,0), 0);
    drive(1, I(LB),  32'h80000004, 0, 0, "rx_stat",  E(0,0,0,4'b0000,0,0,US_RXS,RS_UART,0), 0);
    drive(1, I(LWL), 32'h10000000, 0, 1, "non_mem",  idle(0), 0);

    // TX store accepted immediately
    drive(1, I(SW), A_TX, 1, 0, "tx_now", E(0,0,0,4'b0000,0,1,US_RXD,RS_ALU,0), 0);

    // TX store: five not-ready cycles stall, the sixth releases with the strobe
    for (int i = 0; i < 5; i++)
      drive(1, I(SW), A_TX, 0, 0, "tx_wait5", E(1,0,0,4'b0000,0,0,US_RXD,RS_ALU,0), 0);
    drive(1, I(SW), A_TX, 1, 0, "tx_rel", E(0,0,0,4'b0000,0,1,US_RXD,RS_ALU,0), 0);
    drive(1, FILL, 32'h0, 0, 0, "post_rel", idle(0), 0);

    // Timeout with TX_TIMEOUT=8: seven stalls, dropped on the eighth cycle
    for (int i = 0; i < 7; i++)
      drive(1, I(SW), A_TX, 0, 0, "tmo_stall", E(1,0,0,4'b0000,0,0,US_RXD,RS_ALU,0), 0);
    drive(1, I(SW), A_TX, 0, 0, "tmo_drop", idle(0), 0);
    drive(1, FILL, 32'h0, 0, 0, "err_set1", idle(1), 0);
    drive(1, FILL, 32'h0, 0, 0, "err_set2", idle(1), 0);
    drive(1, I(SW), 32'h80000018, 0, 0, "clr_err", idle(1), 0);
    drive(1, FILL, 32'h0, 0, 0, "err_clr", idle(0), 0);

    // Counters: clear, then 100 cycles with 10 stalled and 5 zero instructions
    drive(1, I(SW), 32'h80000018, 0, 0, "cnt_clr0", idle(0), 0);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 5; i++)
        drive(1, I(SW), A_TX, 0, 0, "win_stall", E(1,0,0,4'b0000,0,0,US_RXD,RS_ALU,0), 0);
      drive(1, I(SW), A_TX, 1, 0, "win_rel", E(0,0,0,4'b0000,0,1,US_RXD,RS_ALU,0), 0);
    end
    for (int i = 0; i < 5; i++)
      drive(1, 32'h0, 32'h0, 0, 0, "win_zero", idle(0), 0);
    for (int i = 0; i < 83; i++)
      drive(1, FILL, 32'h0, 0, 0, "win_fill", idle(0), 0);
    drive(1, I(LW), 32'h80000014, 0, 0, "rd_ins85",  E(0,0,0,4'b0000,0,0,US_RXD,RS_CNT,0), 85);
    drive(1, I(LW), 32'h80000010, 0, 0, "rd_cyc101", E(0,0,0,4'b0000,0,0,US_RXD,RS_CNT,0), 101);
    drive(1, I(SW), 32'h80000018, 0, 0, "cnt_clr1",  idle(0), 0);
    drive(1, I(LW), 32'h80000010, 0, 0, "rd_cyc0",   E(0,0,0,4'b0000,0,0,US_RXD,RS_CNT,0), 0);
    drive(1, I(LW), 32'h80000014, 0, 0, "rd_ins1",   E(0,0,0,4'b0000,0,0,US_RXD,RS_CNT,0), 1);

    // Asynchronous reset while in TX_WAIT: stall drops before any clock edge
    drive(1, I(SW), A_TX, 0, 0, "pre_rst0", E(1,0,0,4'b0000,0,0,US_RXD,RS_ALU,0), 0);
    drive(1, I(SW), A_TX, 0, 0, "pre_rst1", E(1,0,0,4'b0000,0,0,US_RXD,RS_ALU,0), 0);
    drive(0, I(SW), A_TX, 0, 0, "rst_mid",  idle(0), 0);
    drive(1, I(LW), 32'h80000010, 0, 0, "rst_run",  E(0,0,0,4'b0000,0,0,US_RXD,RS_CNT,0), 0);
    drive(1, I(LW), 32'h80000014, 0, 0, "rst_ins1", E(0,0,0,4'b0000,0,0,US_RXD,RS_CNT,0), 1);
    drive(1, FILL, 32'h0, 0, 0, "rst_idle", idle(0), 0);

    repeat (3) @(posedge CLK);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
